// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits carried by the last word of the stream. A chain that is an exact
    // multiple of the word width ends on a full word.
    function automatic int final_word_bits(input int chain_len, input int data_w);
        int rem;
        rem = chain_len % data_w;
        return (rem == 0) ? data_w : rem;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: holds one word and shifts it out MSB-first, nb bits per word.
// Latency: head shows the word MSB the cycle after load; one bit per shift cycle.
// Backpressure: none internally; the parent only pulses shift while the chain accepts bits.
module ccff_word_serializer #(
    parameter int DATA_W = 8,
    parameter int NB_W   = $clog2(DATA_W + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [NB_W-1:0]   load_nb,
    input  logic              shift,
    output logic              head,
    output logic              last_bit
);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [NB_W-1:0]   nb_q, nb_d;

    // Load has priority so a new word can replace the one whose last bit is leaving.
    always_comb begin
        sreg_d = sreg_q;
        nb_d   = nb_q;
        if (load) begin
            sreg_d = load_data;
            nb_d   = load_nb;
        end else if (shift) begin
            sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
            if (nb_q != '0) begin
                nb_d = nb_q - NB_W'(1);
            end
        end
    end

    // Word and remaining-bit registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sreg_q <= '0;
            nb_q   <= '0;
        end else begin
            sreg_q <= sreg_d;
            nb_q   <= nb_d;
        end
    end

    assign head     = sreg_q[DATA_W-1];
    assign last_bit = (nb_q == NB_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams a bitstream into the fabric ccff chain, MSB-first; optional tail readback (CCFF_READBACK_EN).
// Latency: first ccff_shift_en the cycle after the accepting handshake; back-to-back words have no bubble.
// Backpressure: s_ready drops while a word shifts (except its last bit); starvation stalls the chain, rd_* has none.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              config_done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int NB_W     = $clog2(DATA_W + 1);
    localparam int FINAL_NB = final_word_bits(CHAIN_LEN, DATA_W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             config_done_q, config_done_d;
    logic             head_q, head_d;

    logic             ser_load, ser_shift, ser_head, ser_last_bit;
    logic [NB_W-1:0]  ser_nb;
    logic [CNT_W-1:0] cnt_after, load_base;
    logic [31:0]      remaining;
    logic             chain_end;
    logic             restart;

    // Bit bookkeeping: where the count will stand after this cycle, and how many
    // bits the word accepted now must carry.
    always_comb begin
        cnt_after = bit_count_q + CNT_W'(1);
        chain_end = (cnt_after == CNT_W'(CHAIN_LEN));
        load_base = (state_q == SHIFT) ? cnt_after : bit_count_q;
        remaining = 32'(CHAIN_LEN) - 32'(load_base);
        ser_nb    = (remaining <= 32'(DATA_W)) ? NB_W'(FINAL_NB) : NB_W'(DATA_W);
    end

    // Loader FSM: next state, counters and handshake/shift outputs.
    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        config_done_d = config_done_q;
        head_d        = head_q;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        restart       = 1'b0;
        s_ready       = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    restart     = 1'b1;
                    bit_count_d = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    ser_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ser_shift     = 1'b1;
                head_d        = ser_head;
                bit_count_d   = cnt_after;
                if (ser_last_bit) begin
                    if (chain_end) begin
                        config_done_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        // Accept the next word on the last bit so the chain never idles.
                        s_ready = 1'b1;
                        if (s_valid) begin
                            ser_load = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            DONE: begin
                if (start) begin
                    restart       = 1'b1;
                    bit_count_d   = '0;
                    config_done_d = 1'b0;
                    state_d       = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d       = IDLE;
            bit_count_d   = '0;
            config_done_d = 1'b0;
            ser_load      = 1'b0;
            restart       = 1'b0;
        end
        ccff_head = ccff_shift_en ? ser_head : head_q;
    end

    // FSM state, bit counter, sticky done flag and held head bit.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q       <= IDLE;
            bit_count_q   <= '0;
            config_done_q <= 1'b0;
            head_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            config_done_q <= config_done_d;
            head_q        <= head_d;
        end
    end

    assign bit_count   = bit_count_q;
    assign config_done = config_done_q;

    ccff_word_serializer #(
        .DATA_W (DATA_W),
        .NB_W   (NB_W)
    ) u_ser (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .load         (ser_load),
        .load_data    (s_data),
        .load_nb      (ser_nb),
        .shift        (ser_shift),
        .head         (ser_head),
        .last_bit     (ser_last_bit)
    );

`ifdef CCFF_READBACK_EN
    logic [DATA_W-1:0] rb_sreg_q, rb_sreg_d, rb_word;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NB_W-1:0]   rb_cnt_q, rb_cnt_d, rb_cnt_next;
    logic              rd_valid_q, rd_valid_d;

    // Pack tail samples MSB-first; emit full words and a left-aligned final partial word.
    always_comb begin
        rb_sreg_d   = rb_sreg_q;
        rb_cnt_d    = rb_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rb_word     = {rb_sreg_q[DATA_W-2:0], ccff_tail};
        rb_cnt_next = rb_cnt_q + NB_W'(1);
        if (abort || restart) begin
            rb_sreg_d = '0;
            rb_cnt_d  = '0;
        end else if (ccff_shift_en) begin
            if ((rb_cnt_next == NB_W'(DATA_W)) || chain_end) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rb_word << (NB_W'(DATA_W) - rb_cnt_next);
                rb_sreg_d  = '0;
                rb_cnt_d   = '0;
            end else begin
                rb_sreg_d = rb_word;
                rb_cnt_d  = rb_cnt_next;
            end
        end
    end

    // Readback packing registers and output strobe.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rb_sreg_q  <= '0;
            rb_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rb_sreg_q  <= rb_sreg_d;
            rb_cnt_q   <= rb_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic unused_rb;
    assign unused_rb = ccff_tail ^ restart;
    assign rd_data   = '0;
    assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for the ccff bitstream loader with a 20-bit chain model on the serial port.
// Latency: checks first-shift timing, no-bubble streaming and done timing against hand values.
// Backpressure: exercises starvation gaps, abort, start-while-busy and async reset.
module tb_ccff_bitstream_loader;

    localparam int CHAIN_LEN = 20;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 5;

    logic              prog_clk = 1'b0;
    logic              prog_reset_n;
    logic              start, abort, s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic              busy, config_done, rd_valid;
    logic [CNT_W-1:0]  bit_count;
    logic [DATA_W-1:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    ccff_bitstream_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .DATA_W    (DATA_W)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .abort         (abort),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .config_done   (config_done),
        .bit_count     (bit_count),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    always #5 prog_clk = ~prog_clk;

    // The configuration chain itself: a 20-flop shift register.
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    // Monitor: collects shifted bits, the longest internal shift_en gap and readback words.
    logic                 mon_clr = 1'b0;
    logic [CHAIN_LEN-1:0] bits_seen = '0;
    int                   n_bits = 0, gap_run = 0, gap_max = 0, rd_n = 0;
    logic [DATA_W-1:0]    rd_seen [4];
    always @(negedge prog_clk) begin
        if (mon_clr) begin
            bits_seen <= '0;
            n_bits    <= 0;
            gap_run   <= 0;
            gap_max   <= 0;
            rd_n      <= 0;
        end else begin
            if (ccff_shift_en) begin
                bits_seen <= {bits_seen[CHAIN_LEN-2:0], ccff_head};
                n_bits    <= n_bits + 1;
                if (gap_run > gap_max) gap_max <= gap_run;
                gap_run   <= 0;
            end else if (n_bits > 0) begin
                gap_run <= gap_run + 1;
            end
            if (rd_valid) begin
                if (rd_n < 4) rd_seen[rd_n] <= rd_data;
                rd_n <= rd_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge prog_clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one word and return one cycle after its handshake edge.
    task automatic send_word(input logic [DATA_W-1:0] w);
        int n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        check("s_ready_wait", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!config_done && n < 100) begin
            step();
            n++;
        end
        check("done_wait", 32'(config_done), 32'd1);
    endtask

    task automatic send_stream();
        send_word(8'hA5);
        send_word(8'h3C);
        send_word(8'hF0);
    endtask

    initial begin
        int n;
        prog_reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) step();

        // Reset state.
        check("rst_shift_en", 32'(ccff_shift_en), 32'd0);
        check("rst_s_ready",  32'(s_ready),       32'd0);
        check("rst_busy",     32'(busy),          32'd0);
        check("rst_done",     32'(config_done),   32'd0);
        check("rst_bit_count",32'(bit_count),     32'd0);
        check("rst_head",     32'(ccff_head),     32'd0);
        check("rst_rd_valid", 32'(rd_valid),      32'd0);
        check("rst_rd_data",  32'(rd_data),       32'd0);
        prog_reset_n = 1'b1;
        step();
        check("idle_s_ready", 32'(s_ready), 32'd0);

        // Streaming load with s_valid held: 20 contiguous bits.
        clear_mon();
        pulse_start();
        check("load_s_ready", 32'(s_ready), 32'd1);
        check("load_busy",    32'(busy),    32'd1);
        send_word(8'hA5);
        check("first_shift_en", 32'(ccff_shift_en), 32'd1);
        check("first_head",     32'(ccff_head),     32'd1);
        send_word(8'h3C);
        send_word(8'hF0);
        repeat (3) step();
        check("last_bit_en",   32'(ccff_shift_en), 32'd1);
        check("last_bit_done", 32'(config_done),   32'd0);
        check("last_bit_cnt",  32'(bit_count),     32'd19);
        step();
        check("done_flag",   32'(config_done),   32'd1);
        check("done_cnt",    32'(bit_count),     32'd20);
        check("done_en",     32'(ccff_shift_en), 32'd0);
        check("done_busy",   32'(busy),          32'd0);
        check("done_head",   32'(ccff_head),     32'd1);
        check("stream_bits", 32'(bits_seen),     32'h0A53CF);
        check("stream_n",    32'(n_bits),        32'd20);
        check("stream_gap",  32'(gap_max),       32'd0);
        step();
        check("done_sticky", 32'(config_done),   32'd1);

        // Starvation: five LOAD cycles after the first word.
        clear_mon();
        pulse_start();
        check("restart_done", 32'(config_done), 32'd0);
        check("restart_cnt",  32'(bit_count),   32'd0);
        send_word(8'hA5);
        repeat (12) step();
        check("starve_en",   32'(ccff_shift_en), 32'd0);
        check("starve_head", 32'(ccff_head),     32'd1);
        check("starve_cnt",  32'(bit_count),     32'd8);
        send_word(8'h3C);
        send_word(8'hF0);
        wait_done();
        check("starve_bits", 32'(bits_seen), 32'h0A53CF);
        check("starve_n",    32'(n_bits),    32'd20);
        check("starve_gap",  32'(gap_max),   32'd5);

        // Abort after 11 bits, then a clean reload.
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        n = 0;
        while (bit_count != CNT_W'(11) && n < 50) begin
            step();
            n++;
        end
        check("abort_at_11", 32'(bit_count), 32'd11);
        abort = 1'b1;
        check("abort_not_yet", 32'(busy), 32'd1);
        step();
        abort = 1'b0;
        check("abort_busy",  32'(busy),          32'd0);
        check("abort_en",    32'(ccff_shift_en), 32'd0);
        check("abort_ready", 32'(s_ready),       32'd0);
        check("abort_cnt",   32'(bit_count),     32'd0);
        check("abort_done",  32'(config_done),   32'd0);
        check("abort_head",  32'(ccff_head),     32'd1);
        clear_mon();
        pulse_start();
        send_stream();
        wait_done();
        check("reload_bits", 32'(bits_seen), 32'h0A53CF);
        check("reload_n",    32'(n_bits),    32'd20);

        // start while busy is ignored; start+abort together goes IDLE.
        pulse_start();
        send_word(8'hA5);
        repeat (2) step();
        check("busy_cnt_before", 32'(bit_count), 32'd2);
        pulse_start();
        check("busy_start_cnt", 32'(bit_count),     32'd3);
        check("busy_start_en",  32'(ccff_shift_en), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("both_busy",  32'(busy),      32'd0);
        check("both_ready", 32'(s_ready),   32'd0);
        check("both_cnt",   32'(bit_count), 32'd0);

        // Async reset in the middle of a word.
        pulse_start();
        send_word(8'hA5);
        repeat (2) step();
        #3;
        prog_reset_n = 1'b0;
        #1;
        check("arst_en",    32'(ccff_shift_en), 32'd0);
        check("arst_ready", 32'(s_ready),       32'd0);
        check("arst_busy",  32'(busy),          32'd0);
        check("arst_done",  32'(config_done),   32'd0);
        check("arst_cnt",   32'(bit_count),     32'd0);
        #2;
        prog_reset_n = 1'b1;
        step();

        // Preload the chain with ABCDE, then reload and read the old contents back.
        pulse_start();
        send_word(8'hAB);
        send_word(8'hCD);
        send_word(8'hE0);
        wait_done();
        check("preload_chain", 32'(chain), 32'h0ABCDE);
        clear_mon();
        pulse_start();
        send_stream();
        wait_done();
        step();
        check("verify_bits", 32'(bits_seen), 32'h0A53CF);
`ifdef CCFF_READBACK_EN
        check("rb_count", 32'(rd_n), 32'd3);
        check("rb_word0", 32'(rd_seen[0]), 32'hAB);
        check("rb_word1", 32'(rd_seen[1]), 32'hCD);
        check("rb_word2", 32'(rd_seen[2]), 32'hE0);
`else
        check("rb_count", 32'(rd_n),    32'd0);
        check("rb_data",  32'(rd_data), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
